// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall control block.
package hazard_stall_unit_pkg;

  // Register specifier width of the 16-register file.
  localparam int REG_ADDR_W = 4;

  // Register 0 reads as zero, so a load targeting it never creates a hazard.
  localparam int ZERO_REG = 0;

  // Instruction word loaded into IF/ID or ID/EX when flushing or bubbling.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Stall-control FSM states.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next value: add one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall control: load-use stalls, taken-branch squash,
// data-memory freeze and halt drain for the 5-stage 16-bit core.
//
// Handshake note: the *_write outputs are load enables for the pipeline
// registers (1 = capture this cycle); flush/bubble load the NOP word. A
// dmem_busy cycle freezes every register, so any event seen during it is
// re-presented by the held stages in the first non-frozen cycle.
module hazard_stall_unit #(
  parameter int REG_ADDR_W       = hazard_stall_unit_pkg::REG_ADDR_W,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_store,
  input  logic                  id_halt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  id_ex_write,
  output logic                  ex_mem_write,
  output logic                  mem_wb_write,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  import hazard_stall_unit_pkg::*;

  state_e     state_q;
  state_e     state_d;
  logic [1:0] bcnt_q;
  logic [1:0] bcnt_d;
  logic       ldhz;
  logic       stall_inc;
  logic       flush_inc;

  // Load-use compare; store data (rt of a store) is forwarded MEM->MEM.
  always_comb begin
    ldhz = ex_memread && (ex_rd != REG_ADDR_W'(ZERO_REG)) &&
           ((id_uses_rs && (ex_rd == id_rs)) ||
            (id_uses_rt && (ex_rd == id_rt) && !id_is_store));
  end

  // Next state and pipeline controls; reset, then freeze, then the FSM.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    halted       = (state_q == ST_HALT);
    flush_inc    = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      halted       = 1'b0;
      state_d      = ST_RUN;
      bcnt_d       = 2'd0;
    end else if (dmem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (branch_taken) begin
      // Older instruction redirects: squash IF/ID and ID/EX in any state.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      halted       = 1'b0;
      flush_inc    = 1'b1;
      state_d      = ST_RUN;
      bcnt_d       = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ldhz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = ST_LDUSE;
              bcnt_d  = 2'(LOAD_USE_BUBBLES - 1);
            end
          end else if (id_halt) begin
            state_d = ST_HALT;
          end
        end
        ST_LDUSE: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          bcnt_d       = bcnt_q - 2'd1;
          if (bcnt_q <= 2'd1) begin
            state_d = ST_RUN;
            bcnt_d  = 2'd0;
          end
        end
        ST_HALT: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if_id_flush = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          bcnt_d  = 2'd0;
        end
      endcase
    end

    stall_inc = !rst && !pc_write && (state_q != ST_HALT);
  end

  // FSM state and bubble counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      bcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: vector table, random vectors, hand sequences.
module tb_hazard_stall_unit;

  localparam logic [7:0] O_NORM   = 8'b1100_1110;
  localparam logic [7:0] O_STALL  = 8'b0001_1110;
  localparam logic [7:0] O_FLUSH  = 8'b1111_1110;
  localparam logic [7:0] O_FREEZE = 8'b0000_0000;
  localparam logic [7:0] O_HALT   = 8'b0010_1111;
  localparam logic [7:0] O_RESET  = 8'b0011_0000;

  typedef struct {
    logic [3:0] rs;
    logic [3:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_store;
    logic       halt;
    logic       memread;
    logic [3:0] rd;
    logic       taken;
    logic       busy;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, rst3, sat_rst, sat_inc;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_is_store, id_halt, ex_memread;
  logic       branch_taken, dmem_busy;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic        id_ex_write, ex_mem_write, mem_wb_write, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_write3, if_id_write3, if_id_flush3, id_ex_bubble3;
  logic        id_ex_write3, ex_mem_write3, mem_wb_write3, halted3;
  logic [15:0] stall_cnt3, flush_cnt3;
  logic [2:0]  sat_count;

  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_stall = 0;
  logic [15:0] exp_flush = 0;
  vec_t        vecs[12];

  // Clock generation.
  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_store(id_is_store),
    .id_halt(id_halt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_stall_unit #(.LOAD_USE_BUBBLES(3)) dut3 (
    .clk(clk), .rst(rst3), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_store(id_is_store),
    .id_halt(id_halt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write3), .if_id_write(if_id_write3), .if_id_flush(if_id_flush3),
    .id_ex_bubble(id_ex_bubble3), .id_ex_write(id_ex_write3),
    .ex_mem_write(ex_mem_write3), .mem_wb_write(mem_wb_write3), .halted(halted3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  sat_counter #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(sat_rst), .inc(sat_inc), .count(sat_count)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rs, input logic [3:0] rt,
                              input logic ur, input logic ut, input logic st,
                              input logic hl, input logic mr, input logic [3:0] rd,
                              input logic tk, input logic bz, input logic [7:0] e);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rs = ur; v.uses_rt = ut; v.is_store = st;
    v.halt = hl; v.memread = mr; v.rd = rd; v.taken = tk; v.busy = bz; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
    id_is_store = v.is_store; id_halt = v.halt; ex_memread = v.memread;
    ex_rd = v.rd; branch_taken = v.taken; dmem_busy = v.busy;
  endtask

  // Drive one cycle on dut, check outputs mid-cycle and counters after the edge.
  task automatic apply(input string name, input vec_t v);
    logic [7:0] e;
    drive(v);
    exp_q.push_back(v.exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check({name, "_outs"}, 16'({pc_write, if_id_write, if_id_flush, id_ex_bubble,
                               id_ex_write, ex_mem_write, mem_wb_write, halted}), 16'(e));
    if (!e[7] && !e[0]) exp_stall++;
    if (v.taken && !v.busy) exp_flush++;
    @(posedge clk); #1;
    check({name, "_stall_cnt"}, stall_cnt, exp_stall);
    check({name, "_flush_cnt"}, flush_cnt, exp_flush);
  endtask

  function automatic logic [7:0] ref_out(input vec_t v);
    logic hz;
    hz = v.memread && (v.rd != 4'd0) &&
         ((v.uses_rs && v.rd == v.rs) || (v.uses_rt && v.rd == v.rt && !v.is_store));
    return v.taken ? O_FLUSH : (hz ? O_STALL : O_NORM);
  endfunction

  task automatic check3(input string name, input logic [7:0] e);
    @(negedge clk);
    check(name, 16'({pc_write3, if_id_write3, if_id_flush3, id_ex_bubble3,
                     id_ex_write3, ex_mem_write3, mem_wb_write3, halted3}), 16'(e));
    @(posedge clk); #1;
  endtask

  vec_t idle, hz3;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM);
    hz3  = mk(3, 0, 1, 0, 0, 0, 1, 3, 0, 0, O_STALL);
    vecs[0]  = idle;
    vecs[1]  = hz3;
    vecs[2]  = mk(5, 3, 1, 1, 1, 0, 1, 3, 0, 0, O_NORM);
    vecs[3]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, O_NORM);
    vecs[4]  = mk(1, 7, 1, 1, 0, 0, 1, 7, 0, 0, O_STALL);
    vecs[5]  = mk(4, 0, 0, 0, 0, 0, 1, 4, 0, 0, O_NORM);
    vecs[6]  = mk(3, 3, 1, 1, 0, 0, 0, 3, 0, 0, O_NORM);
    vecs[7]  = mk(3, 0, 1, 0, 0, 0, 1, 3, 1, 0, O_FLUSH);
    vecs[8]  = mk(2, 2, 1, 1, 0, 0, 0, 9, 1, 0, O_FLUSH);
    vecs[9]  = mk(6, 1, 1, 1, 1, 0, 1, 6, 0, 0, O_STALL);
    vecs[10] = mk(15, 0, 1, 0, 0, 0, 1, 15, 0, 0, O_STALL);
    vecs[11] = mk(1, 2, 1, 1, 0, 0, 1, 3, 0, 0, O_NORM);

    rst = 1'b1; rst3 = 1'b1; sat_rst = 1'b1; sat_inc = 1'b0;
    drive(idle);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_outs", 16'({pc_write, if_id_write, if_id_flush, id_ex_bubble,
                             id_ex_write, ex_mem_write, mem_wb_write, halted}), 16'(O_RESET));
    check("reset_stall_cnt", stall_cnt, 16'd0);
    check("reset_flush_cnt", flush_cnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 20; i++) begin
      vec_t r;
      r = mk(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 0, O_NORM);
      r.exp = ref_out(r);
      apply($sformatf("rand%0d", i), r);
    end

    // Load-use stall lasts one cycle, then normal flow.
    apply("lu_stall", hz3);
    apply("lu_after", idle);

    // Freeze over a pending load-use hazard, then the single bubble.
    for (int i = 0; i < 4; i++) begin
      vec_t f;
      f = hz3; f.busy = 1'b1; f.exp = O_FREEZE;
      apply($sformatf("frz%0d", i), f);
    end
    apply("frz_bubble", hz3);
    apply("frz_after", idle);

    // Branch seen during freeze is acted on afterwards.
    apply("frz_br", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_FREEZE));
    apply("frz_br_rel", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FLUSH));

    // Halt: HLT advances, fetch stops, wrong-path branch resumes.
    apply("hlt_issue", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_NORM));
    apply("hlt_0", idle_halt());
    apply("hlt_1", idle_halt());
    apply("hlt_frz", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b0000_0001));
    apply("hlt_br", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FLUSH));
    apply("hlt_resume", idle);

    // Three-bubble instance: full stall sequence.
    rst3 = 1'b0;
    drive(idle); check3("lub3_idle", O_NORM);
    drive(hz3);  check3("lub3_s0", O_STALL);
    drive(idle); check3("lub3_s1", O_STALL);
    check3("lub3_s2", O_STALL);
    check3("lub3_run", O_NORM);
    check("lub3_stall_cnt", stall_cnt3, 16'd3);

    // Reset in the second stall cycle discards the remaining bubbles.
    drive(hz3);  check3("rst3_s0", O_STALL);
    drive(idle); rst3 = 1'b1; check3("rst3_outs", O_RESET);
    rst3 = 1'b0; check3("rst3_run", O_NORM);
    check("rst3_stall_cnt", stall_cnt3, 16'd0);
    check("rst3_flush_cnt", flush_cnt3, 16'd0);

    // Saturation of a narrow counter.
    @(negedge clk);
    check("sat_reset", 16'(sat_count), 16'd0);
    sat_rst = 1'b0; sat_inc = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_mid", 16'(sat_count), 16'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_top", 16'(sat_count), 16'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic vec_t idle_halt();
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HALT);
    return v;
  endfunction

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline control block complementing the forwarding logic. It detects hazards that forwarding cannot resolve and issues the corresponding stall, bubble, flush and freeze controls to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Covers load-use stalls, taken-branch squash, multi-cycle data-memory freeze and halt drain.
- Sits beside the forwarding unit in the 5-stage 16-bit core and holds a small FSM plus saturating performance counters.

Parameters:
- REG_ADDR_W, 4, register specifier width (16 registers; register 0 is hardwired zero).
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1 with MEM-EX forwarding present; legal range 1..3).
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rt  in  REG_ADDR_W  source register 2 of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_store  in  1  ID instruction is a store; rt is its store data.
- id_halt  in  1  ID instruction is HLT.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- dmem_busy  in  1  data memory has not completed the MEM-stage access.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  load NOP into ID/EX.
- id_ex_write  out  1  ID/EX load enable.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_write  out  1  MEM/WB load enable.
- halted  out  1  fetch stopped by HLT.
- stall_cnt  out  CNT_W  cycles with pc_write=0, excluding reset and HALT.
- flush_cnt  out  CNT_W  number of taken-branch flushes.

Behaviour:
- FSM states: RUN, LDUSE, HALT. Bubble counter bcnt is 2 bits.
- Reset (rst=1 at a clk edge): state=RUN, bcnt=0, both counters=0.
- While rst is high, outputs are: all *_write=0, if_id_flush=1, id_ex_bubble=1, halted=0.
- Load-use hazard (combinational):
  - ldhz = ex_memread & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt & ~id_is_store)).
  - A store-data dependency alone does not stall; MEM-MEM forwarding covers it.
- Freeze overlay: dmem_busy=1 forces pc_write, if_id_write, id_ex_write, ex_mem_write and mem_wb_write all to 0, and forces flush=0 and bubble=0.
  - FSM state, bcnt and flush_cnt hold. stall_cnt increments.
  - Freeze has priority over every other event. A branch_taken seen during freeze is acted on in the first non-frozen cycle, because EX is held.
- RUN:
  - Defaults: all writes=1, flush=0, bubble=0.
  - branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_cnt++; stay in RUN. This takes priority over ldhz and id_halt.
  - Else if ldhz: pc_write=0, if_id_write=0, id_ex_bubble=1. If LOAD_USE_BUBBLES>1, go to LDUSE with bcnt=LOAD_USE_BUBBLES-1.
  - Else if id_halt: go to HALT next cycle. HLT itself advances into EX this cycle.
- LDUSE:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1; bcnt decrements.
  - Go to RUN when bcnt reaches 0.
  - branch_taken in LDUSE (older instruction) applies the RUN flush outputs and goes to RUN, because the stalled instruction is squashed.
- HALT:
  - Outputs: pc_write=0, if_id_write=0, if_id_flush=1; downstream writes=1 so older instructions drain; halted=1.
  - branch_taken in HALT means the HLT was on a wrong path: apply the flush outputs, go to RUN, halted=0.
  - Otherwise stay in HALT until reset.
- Counters saturate at all-ones and never wrap.
- Each cycle where pc_write=0, not in HALT and not in reset increments stall_cnt.
- Reset mid-stall or mid-freeze returns to RUN on the next edge. No partial bubble count survives.

Decomposition:
- Shared pipeline package:
  - state enum {RUN, LDUSE, HALT}.
  - REG_ADDR_W.
  - ZERO_REG constant.
  - NOP encoding used by the flush/bubble consumers.
- One sub-module: sat_counter (parameter CNT_W, inputs inc and rst), instantiated twice for stall_cnt and flush_cnt.
- Hazard compare and FSM stay in the top module.

Test Plan:
- LW R3 in EX (ex_memread=1, ex_rd=3), ADD in ID with id_rs=3, id_uses_rs=1 -> exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1; next cycle all writes=1.
- ex_rd=3 load, SW in ID with id_rt=3, id_is_store=1, id_rs=5 -> no stall, all writes=1. Same with ex_rd=0 and id_rs=0 -> no stall.
- dmem_busy high for 4 cycles during a load-use stall -> all five write enables 0 for 4 cycles, bubble held 0, stall_cnt=5 after release, then 1 bubble cycle.
- branch_taken=1 coincident with ldhz=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; no stall; flush_cnt=1.
- id_halt=1 in RUN -> halted=1 next cycle with pc_write=0 and if_id_flush=1. branch_taken=1 two cycles later -> RUN, halted=0, flush_cnt++.
- LOAD_USE_BUBBLES=3 with a hazard and rst asserted in the 2nd stall cycle -> outputs follow the reset values; after rst drops, state=RUN, stall_cnt=0, flush_cnt=0.
